// File: rtl/imm_gen_stage.sv
// Immediate generator stage: classifies an RV32 instruction, sign-extends its
// immediate and presents it behind a valid/ready handshake with a skid entry.
module imm_gen_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_imm,
    output logic [2:0]      out_fmt,
    output logic            out_illegal,
    output logic [31:0]     out_instr
);

    localparam logic [2:0] FMT_R = 3'd0;
    localparam logic [2:0] FMT_I = 3'd1;
    localparam logic [2:0] FMT_S = 3'd2;
    localparam logic [2:0] FMT_B = 3'd3;
    localparam logic [2:0] FMT_U = 3'd4;
    localparam logic [2:0] FMT_J = 3'd5;

    typedef struct packed {
        logic [XLEN-1:0] imm;
        logic [2:0]      fmt;
        logic            illegal;
        logic [31:0]     instr;
    } entry_t;

    entry_t             dec;
    entry_t             main_q;
    entry_t             skid_q;
    logic               main_valid;
    logic               skid_valid;
    logic signed [31:0] imm32;
    logic               accept;
    logic               main_open;
    logic               skid_next;

    // Decode format and immediate from the incoming word (pure bit selection)
    always_comb begin
        imm32 = '0;
        dec.fmt = FMT_R;
        dec.illegal = 1'b0;
        dec.instr = in_instr;
        if (in_instr[1:0] != 2'b11) begin
            dec.illegal = 1'b1;
        end else begin
            unique case (in_instr[6:0])
                7'b0010011, 7'b0000011, 7'b1100111,
                7'b1110011, 7'b0001111: begin
                    dec.fmt = FMT_I;
                    imm32 = {{21{in_instr[31]}}, in_instr[30:20]};
                end
                7'b0100011: begin
                    dec.fmt = FMT_S;
                    imm32 = {{21{in_instr[31]}}, in_instr[30:25],
                             in_instr[11:7]};
                end
                7'b1100011: begin
                    dec.fmt = FMT_B;
                    imm32 = {{20{in_instr[31]}}, in_instr[7],
                             in_instr[30:25], in_instr[11:8], 1'b0};
                end
                7'b0110111, 7'b0010111: begin
                    dec.fmt = FMT_U;
                    imm32 = {in_instr[31:12], 12'b0};
                end
                7'b1101111: begin
                    dec.fmt = FMT_J;
                    imm32 = {{12{in_instr[31]}}, in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
                end
                7'b0110011: begin
                    dec.fmt = FMT_R;
                end
                default: begin
                    dec.illegal = 1'b1;
                end
            endcase
        end
        dec.imm = XLEN'(imm32);
    end

    // Handshake bookkeeping; skid can only be occupied while main is held
    always_comb begin
        accept = in_valid && in_ready;
        main_open = !main_valid || out_ready;
        skid_next = main_open ? 1'b0 : (skid_valid || accept);
    end

    // Main/skid storage with strict FIFO order and registered in_ready
    always_ff @(posedge clk) begin
        if (rst) begin
            main_q <= '0;
            skid_q <= '0;
            main_valid <= 1'b0;
            skid_valid <= 1'b0;
            in_ready <= 1'b0;
        end else begin
            if (main_open) begin
                if (skid_valid) begin
                    main_q <= skid_q;
                    main_valid <= 1'b1;
                    skid_valid <= 1'b0;
                end else if (accept) begin
                    main_q <= dec;
                    main_valid <= 1'b1;
                end else begin
                    main_valid <= 1'b0;
                end
            end else if (accept) begin
                skid_q <= dec;
                skid_valid <= 1'b1;
            end
            in_ready <= !skid_next;
        end
    end

    assign out_valid   = main_valid;
    assign out_imm     = main_q.imm;
    assign out_fmt     = main_q.fmt;
    assign out_illegal = main_q.illegal;
    assign out_instr   = main_q.instr;

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: table of decode vectors streamed
// back-to-back, plus backpressure/skid ordering and mid-stream reset cases.
module tb_imm_gen_stage;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_imm;
    logic [2:0]  out_fmt;
    logic        out_illegal;
    logic [31:0] out_instr;

    int checks;
    int failures;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] imm;
        logic [2:0]  fmt;
        logic        illegal;
    } vec_t;

    vec_t vecs[15];

    imm_gen_stage #(.XLEN(32)) dut (
        .clk(clk),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_imm(out_imm),
        .out_fmt(out_fmt),
        .out_illegal(out_illegal),
        .out_instr(out_instr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = w;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    logic [31:0] got[$];
    int          accepted;

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        in_valid = 1'b0;
        in_instr = '0;
        out_ready = 1'b1;

        vecs[0]  = '{32'hFFB00093, 32'hFFFFFFFB, 3'd1, 1'b0};
        vecs[1]  = '{32'hFE20AA23, 32'hFFFFFFF4, 3'd2, 1'b0};
        vecs[2]  = '{32'h123452B7, 32'h12345000, 3'd4, 1'b0};
        vecs[3]  = '{32'hFE000CE3, 32'hFFFFFFF8, 3'd3, 1'b0};
        vecs[4]  = '{32'hFFDFF06F, 32'hFFFFFFFC, 3'd5, 1'b0};
        vecs[5]  = '{32'h00000000, 32'h00000000, 3'd0, 1'b1};
        vecs[6]  = '{32'h00000033, 32'h00000000, 3'd0, 1'b0};
        vecs[7]  = '{32'h00412083, 32'h00000004, 3'd1, 1'b0};
        vecs[8]  = '{32'hFFFFF097, 32'hFFFFF000, 3'd4, 1'b0};
        vecs[9]  = '{32'h4030D093, 32'h00000403, 3'd1, 1'b0};
        vecs[10] = '{32'h0000007F, 32'h00000000, 3'd0, 1'b1};
        vecs[11] = '{32'hFFB00091, 32'h00000000, 3'd0, 1'b1};
        vecs[12] = '{32'h0010006F, 32'h00000800, 3'd5, 1'b0};
        vecs[13] = '{32'h000000E3, 32'h00000800, 3'd3, 1'b0};
        vecs[14] = '{32'h0020A423, 32'h00000008, 3'd2, 1'b0};

        // reset state while rst is held
        repeat (2) @(posedge clk);
        #1;
        check("rst out_valid", 32'(out_valid), 32'd0);
        check("rst out_imm", out_imm, 32'd0);
        check("rst out_fmt", 32'(out_fmt), 32'd0);
        check("rst out_illegal", 32'(out_illegal), 32'd0);
        check("rst out_instr", out_instr, 32'd0);
        check("rst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post-rst in_ready", 32'(in_ready), 32'd1);

        // stream the table back-to-back: one result per cycle, no bubbles
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_instr = vecs[i].instr;
            @(posedge clk);
            #1;
            check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
            check($sformatf("v%0d imm", i), out_imm, vecs[i].imm);
            check($sformatf("v%0d fmt", i), 32'(out_fmt),
                  32'(vecs[i].fmt));
            check($sformatf("v%0d illegal", i), 32'(out_illegal),
                  32'(vecs[i].illegal));
            check($sformatf("v%0d instr", i), out_instr, vecs[i].instr);
            check($sformatf("v%0d in_ready", i), 32'(in_ready), 32'd1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("idle out_valid", 32'(out_valid), 32'd0);

        // backpressure: w0 -> main, w1 -> skid, w2 held upstream
        @(negedge clk);
        out_ready = 1'b0;
        push(32'hFFB00093);
        push(32'hFE20AA23);
        check("bp in_ready low", 32'(in_ready), 32'd0);
        @(negedge clk);
        in_valid = 1'b1;
        in_instr = 32'h123452B7;
        repeat (3) @(posedge clk);
        #1;
        check("bp out_valid", 32'(out_valid), 32'd1);
        check("bp held instr", out_instr, 32'hFFB00093);
        check("bp held imm", out_imm, 32'hFFFFFFFB);
        check("bp in_ready still low", 32'(in_ready), 32'd0);

        // release: words must emerge 0,1,2 exactly once
        @(negedge clk);
        out_ready = 1'b1;
        accepted = 0;
        for (int c = 0; c < 10; c++) begin
            if (c > 0) @(negedge clk);
            if (out_valid) got.push_back(out_instr);
            accepted = (in_valid && in_ready) ? 1 : 0;
            @(posedge clk);
            #1;
            if (accepted != 0) in_valid = 1'b0;
        end
        check("drain count", 32'(got.size()), 32'd3);
        if (got.size() == 3) begin
            check("drain w0", got[0], 32'hFFB00093);
            check("drain w1", got[1], 32'hFE20AA23);
            check("drain w2", got[2], 32'h123452B7);
        end
        check("drain in_valid dropped", 32'(in_valid), 32'd0);
        check("drain in_ready", 32'(in_ready), 32'd1);

        // mid-stream reset with both entries full
        @(negedge clk);
        out_ready = 1'b0;
        push(32'hFE000CE3);
        push(32'hFFDFF06F);
        check("full in_ready", 32'(in_ready), 32'd0);
        check("full out_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mrst out_valid", 32'(out_valid), 32'd0);
        check("mrst out_imm", out_imm, 32'd0);
        check("mrst out_fmt", 32'(out_fmt), 32'd0);
        check("mrst out_illegal", 32'(out_illegal), 32'd0);
        check("mrst out_instr", out_instr, 32'd0);
        check("mrst in_ready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("mrst+1 in_ready", 32'(in_ready), 32'd1);
        check("mrst+1 out_valid", 32'(out_valid), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("mrst no ghost", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
